instr_mem_responder: RTL
========================

Name: instr_mem_responder

Overview:
- Memory-side responder for the fetch stage: accepts a word-address request from fetch (PCF), returns the instruction after a fixed number of wait cycles, and raises a stall request toward fetch while a fetch is outstanding.
- Replaces the combinational instruction memory with a latency-accurate, flushable, loadable program store.
- Sits between fetch and the program RAM.
- A load port lets the bench or boot logic write the program.

Parameters:
- N, 32, data/address width.
- DEPTH, 256, number of 32-bit instruction words (power of two).
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ReqF  in  1  fetch requests the instruction at PCF.
- PCF  in  N  byte address from fetch.
- FlushF  in  1  cancels any in-flight request (branch or redirect).
- LoadEn  in  1  program-load write strobe.
- LoadAddr  in  $clog2(DEPTH)  word index to write.
- LoadData  in  N  word to write.
- InstrF  out  N  returned instruction.
- InstrValidF  out  1  InstrF valid this cycle (single-cycle pulse per request).
- FaultF  out  1  response is a fault (misaligned or out of range); qualified by InstrValidF.
- StallReqF  out  1  fetch must hold PC; equals ReqF & ~InstrValidF (combinational from registered state).

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, cnt=0, InstrF=0, InstrValidF=0, FaultF=0.
  - RAM contents are not cleared.
  - Reset while in WAIT or RESP aborts the transaction; no response is produced.
- States: IDLE, WAIT, RESP.
- IDLE:
  - ReqF=1 and LoadEn=0 at edge k → latch word index PCF[$clog2(DEPTH)+1:2] and fault flags, set cnt=LATENCY-1, go to WAIT.
  - ReqF=1 with LoadEn=1 → the load wins; the request is not accepted and is retried next cycle.
- WAIT:
  - cnt≠0 → decrement.
  - cnt==0 → read the RAM at the latched index, register InstrF, set InstrValidF=1, go to RESP.
  - Result: InstrValidF is high in the cycle after edge k+LATENCY.
- RESP (one cycle):
  - InstrValidF drops at the next edge.
  - If ReqF=1 in RESP, the new request is accepted at that edge (back-to-back), going to WAIT with cnt=LATENCY-1. Otherwise go to IDLE.
- Faults:
  - PCF[1:0]≠0 or PCF[N-1:$clog2(DEPTH)+2]≠0 at acceptance → response has InstrF=32'h0000_0000 (NOP) and FaultF=1.
  - The RAM is not read for a fault.
  - FaultF is 0 on every non-fault response.
- Flush:
  - FlushF=1 in WAIT or RESP → go to IDLE next edge, InstrValidF=0, no response delivered.
  - FlushF=1 together with ReqF=1 → the in-flight request is dropped and the new PCF is accepted at the same edge (goes to WAIT).
  - FlushF in IDLE behaves the same as ReqF alone.
- Load:
  - LoadEn writes RAM[LoadAddr]=LoadData at the edge, in any state.
  - Same-edge read and write to the same index returns the old data (read-before-write).
- StallReqF never depends on LoadEn or FlushF directly.

Decomposition:
- Package imem_resp_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - NOP_INSTR constant = 32'h0.
  - cnt width localparam = 4.
- Sub-module instr_ram:
  - single port.
  - synchronous write.
  - synchronous read with read-enable.
  - parameters N and DEPTH.

Test Plan:
- Reset then single fetch: LoadEn writes RAM[3]=32'hDEADBEEF; ReqF=1, PCF=12 accepted at edge k → InstrValidF=1, InstrF=DEADBEEF, FaultF=0 after edge k+2. StallReqF=1 during cycles k..k+1 and 0 during the valid cycle.
- Back-to-back: ReqF held high with PCF=0,4,8 (RAM 0..2 = 1,2,3) → responses 1,2,3 every 3 cycles with no lost or duplicated InstrValidF pulse.
- Faults:
  - PCF=32'h6 → InstrValidF=1, FaultF=1, InstrF=0.
  - PCF=32'h400 (DEPTH=256) → same result.
- Flush redirect: request PCF=0 accepted; in the WAIT cycle FlushF=1 and ReqF=1 with PCF=8 → only one response is delivered, InstrF=RAM[2], two cycles after the flush edge.
- Reset mid-WAIT: rst pulsed low asynchronously between edges → outputs go to 0 immediately, no response appears afterward, RAM contents unchanged.
- Load collision: in IDLE, LoadEn=1 and ReqF=1 → request not accepted that cycle and StallReqF stays 1. The next cycle it is accepted and returns the newly loaded word.

Source files
------------

// File: rtl/imem_resp_pkg.sv
// Shared types and constants for the fetch-side instruction memory responder.
package imem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          CNT_W     = 4;

endpackage

// File: rtl/instr_ram.sv
// Program store: one clock, synchronous write, registered read with enable.
// A same-edge read and write to one index returns the old word.
module instr_ram #(
  parameter int N     = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [N-1:0]             i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [N-1:0]             o_rdata
);

  logic [N-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Latency-accurate instruction responder for fetch: accepts a byte address,
// answers LATENCY cycles later, supports flush/redirect and program loading.
module instr_mem_responder
  import imem_resp_pkg::*;
#(
  parameter int N       = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ReqF,
  input  logic [N-1:0]             PCF,
  input  logic                     FlushF,
  input  logic                     LoadEn,
  input  logic [$clog2(DEPTH)-1:0] LoadAddr,
  input  logic [N-1:0]             LoadData,
  output logic [N-1:0]             InstrF,
  output logic                     InstrValidF,
  output logic                     FaultF,
  output logic                     StallReqF
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [AW-1:0]    r_idx;
  logic             r_fault;
  logic             r_valid, w_valid_d;
  logic             w_accept, w_latch, w_re, w_req_fault;
  logic [N-1:0]     w_rdata;

  // Misaligned or beyond the program store; such requests never touch the RAM.
  assign w_req_fault = (PCF[1:0] != 2'b00) || ((PCF >> (AW + 2)) != '0);
  assign w_accept    = ReqF & ~LoadEn;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_valid_d = 1'b0;
    w_re      = 1'b0;
    w_latch   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_d = WAIT;
          w_cnt_d   = CNT_INIT;
          w_latch   = 1'b1;
        end
      end
      WAIT: begin
        if (FlushF) begin
          if (w_accept) begin
            w_state_d = WAIT;
            w_cnt_d   = CNT_INIT;
            w_latch   = 1'b1;
          end else begin
            w_state_d = IDLE;
          end
        end else if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end else begin
          w_valid_d = 1'b1;
          w_re      = ~r_fault;
          w_state_d = RESP;
        end
      end
      RESP: begin
        if (w_accept) begin
          w_state_d = WAIT;
          w_cnt_d   = CNT_INIT;
          w_latch   = 1'b1;
        end else begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_valid <= w_valid_d;
      if (w_latch) r_fault <= w_req_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch) r_idx <= PCF[AW+1:2];
  end

  instr_ram #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (LoadEn),
    .i_waddr (LoadAddr),
    .i_wdata (LoadData),
    .i_re    (w_re),
    .i_raddr (r_idx),
    .o_rdata (w_rdata)
  );

  // Gating by r_valid keeps the outputs at zero out of reset and between responses.
  assign InstrF      = (r_valid && !r_fault) ? w_rdata : N'(NOP_INSTR);
  assign InstrValidF = r_valid;
  assign FaultF      = r_valid & r_fault;
  assign StallReqF   = ReqF & ~r_valid;

endmodule
